// File: rtl/hbm_axi_pkg.sv
// Shared AXI read-path types and constants for the HBM/DDR responder.
package hbm_axi_pkg;

    localparam int MAX_ID_W   = 16;
    localparam int MAX_ADDR_W = 64;
    localparam int TS_W       = 16;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // One queued read request; fields are sized for the widest supported bus.
    typedef struct packed {
        logic [MAX_ID_W-1:0]   id;
        logic [MAX_ADDR_W-1:0] addr;
        logic [3:0]            len;
        logic [1:0]            burst;
        logic [TS_W-1:0]       ts;
    } rd_req_t;

    // Address of the following beat. WRAP and the reserved encoding step like INCR.
    function automatic logic [MAX_ADDR_W-1:0] next_beat_addr(
        input logic [MAX_ADDR_W-1:0] addr,
        input logic [1:0]            burst,
        input logic [MAX_ADDR_W-1:0] step,
        input logic [MAX_ADDR_W-1:0] mask
    );
        return (burst == BURST_FIXED) ? addr : ((addr + step) & mask);
    endfunction

endpackage

// File: rtl/rd_req_fifo.sv
// Show-ahead synchronous FIFO of read requests.
module rd_req_fifo
    import hbm_axi_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  rd_req_t                  push_data,
    input  logic                     pop,
    output rd_req_t                  head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    rd_req_t       mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Entry storage.
    // NOTE: the storage array has no reset; only pointers and count decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hbm_rd_responder.sv
// AXI4 read responder: queues AR requests and replays them after a fixed
// latency as bursts of address-pattern data.
module hbm_rd_responder
    import hbm_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 33,
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 5,
    parameter int DEPTH      = 8,
    parameter int LATENCY    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_axi_ARVALID,
    input  logic [ADDR_WIDTH-1:0] s_axi_ARADDR,
    input  logic [ID_WIDTH-1:0]   s_axi_ARID,
    input  logic [3:0]            s_axi_ARLEN,
    input  logic [2:0]            s_axi_ARSIZE,
    input  logic [1:0]            s_axi_ARBURST,
    output logic                  s_axi_ARREADY,
    output logic                  s_axi_RVALID,
    output logic [DATA_WIDTH-1:0] s_axi_RDATA,
    output logic                  s_axi_RLAST,
    output logic [ID_WIDTH-1:0]   s_axi_RID,
    output logic [1:0]            s_axi_RRESP,
    input  logic                  s_axi_RREADY,
    output logic [31:0]           req_cnt,
    output logic [31:0]           beat_cnt
);
    localparam int          LANES      = DATA_WIDTH / 64;
    localparam logic [63:0] BEAT_STEP  = 64'(DATA_WIDTH / 8);
    localparam logic [63:0] ALIGN_MASK = ~(BEAT_STEP - 64'd1);
    localparam logic [63:0] ADDR_MASK  = (64'd1 << ADDR_WIDTH) - 64'd1;
    localparam logic [15:0] DUE_AGE    = 16'(LATENCY - 1);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;

    r_state_t              state;
    logic [15:0]           now_q;
    logic                  live_q;
    rd_req_t               push_req;
    rd_req_t               head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  fifo_pop;
    logic [15:0]           head_age;
    logic                  head_due;
    logic                  load_now;
    logic [63:0]           cur_addr;
    logic [63:0]           nxt_addr;
    logic [3:0]            cur_len;
    logic [1:0]            cur_burst;
    logic [3:0]            beat_idx;
    logic                  unused_bits;

    // live_q keeps ARREADY low while reset is held.
    assign s_axi_ARREADY = live_q && !fifo_full;
    assign ar_hs         = s_axi_ARVALID && s_axi_ARREADY;
    assign r_hs          = s_axi_RVALID && s_axi_RREADY;
    assign fifo_pop      = (state == R_BURST) && r_hs && s_axi_RLAST;
    assign head_age      = now_q - head.ts;
    assign head_due      = !fifo_empty && (head_age >= DUE_AGE);
    assign load_now      = (state != R_BURST) && head_due;
    assign nxt_addr      = next_beat_addr(cur_addr, cur_burst, BEAT_STEP, ADDR_MASK);
    assign unused_bits   = ^{s_axi_ARSIZE, fifo_count, head.id};

    // Request record captured on an AR handshake, address aligned to the beat size.
    // NOTE: every field gets a value on every pass so no latch is inferred.
    always_comb begin
        push_req       = '0;
        push_req.id    = MAX_ID_W'(s_axi_ARID);
        push_req.addr  = 64'(s_axi_ARADDR) & ALIGN_MASK;
        push_req.len   = s_axi_ARLEN;
        push_req.burst = s_axi_ARBURST;
        push_req.ts    = now_q;
    end

    rd_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ar_hs),
        .push_data (push_req),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Free-running timestamp, ready flag and handshake counters.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            now_q    <= '0;
            live_q   <= 1'b0;
            req_cnt  <= '0;
            beat_cnt <= '0;
        end else begin
            now_q  <= now_q + 16'd1;
            live_q <= 1'b1;
            if (ar_hs) req_cnt  <= req_cnt + 32'd1;
            if (r_hs)  beat_cnt <= beat_cnt + 32'd1;
        end
    end

    // Response FSM: wait for the head to age, then stream its beats; the
    // return to R_IDLE after RLAST gives one idle cycle between bursts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= R_IDLE;
            s_axi_RVALID <= 1'b0;
            s_axi_RLAST  <= 1'b0;
            s_axi_RDATA  <= '0;
            s_axi_RID    <= '0;
            s_axi_RRESP  <= RESP_OKAY;
            cur_addr     <= '0;
            cur_len      <= '0;
            cur_burst    <= BURST_FIXED;
            beat_idx     <= '0;
        end else begin
            case (state)
                R_IDLE, R_WAIT: begin
                    if (load_now) begin
                        state        <= R_BURST;
                        s_axi_RVALID <= 1'b1;
                        s_axi_RLAST  <= (head.len == 4'd0);
                        s_axi_RDATA  <= {LANES{head.addr}};
                        s_axi_RID    <= head.id[ID_WIDTH-1:0];
                        s_axi_RRESP  <= (head.burst == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
                        cur_addr     <= head.addr;
                        cur_len      <= head.len;
                        cur_burst    <= head.burst;
                        beat_idx     <= '0;
                    end else if (!fifo_empty) begin
                        state <= R_WAIT;
                    end
                end
                R_BURST: begin
                    if (s_axi_RREADY) begin
                        if (s_axi_RLAST) begin
                            state        <= R_IDLE;
                            s_axi_RVALID <= 1'b0;
                            s_axi_RLAST  <= 1'b0;
                        end else begin
                            cur_addr    <= nxt_addr;
                            s_axi_RDATA <= {LANES{nxt_addr}};
                            beat_idx    <= beat_idx + 4'd1;
                            s_axi_RLAST <= ((beat_idx + 4'd1) == cur_len);
                        end
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hbm_rd_responder.sv
// Self-checking bench for hbm_rd_responder with a transaction-level model.
module tb_hbm_rd_responder;
    import hbm_axi_pkg::*;

    localparam int ADDR_WIDTH = 33;
    localparam int DATA_WIDTH = 256;
    localparam int ID_WIDTH   = 5;
    localparam int DEPTH      = 8;
    localparam int LATENCY    = 16;
    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int LANES      = DATA_WIDTH / 64;
    localparam logic [63:0] AMASK = (64'd1 << ADDR_WIDTH) - 64'd1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  arvalid = 1'b0;
    logic [ADDR_WIDTH-1:0] araddr = '0;
    logic [ID_WIDTH-1:0]   arid = '0;
    logic [3:0]            arlen = '0;
    logic [2:0]            arsize = 3'd5;
    logic [1:0]            arburst = 2'b01;
    logic                  arready;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rlast;
    logic [ID_WIDTH-1:0]   rid;
    logic [1:0]            rresp;
    logic                  rready = 1'b0;
    logic [31:0]           req_cnt;
    logic [31:0]           beat_cnt;

    always #5 clk = ~clk;

    hbm_rd_responder #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH),
        .DEPTH(DEPTH), .LATENCY(LATENCY)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_ARVALID(arvalid), .s_axi_ARADDR(araddr), .s_axi_ARID(arid),
        .s_axi_ARLEN(arlen), .s_axi_ARSIZE(arsize), .s_axi_ARBURST(arburst),
        .s_axi_ARREADY(arready),
        .s_axi_RVALID(rvalid), .s_axi_RDATA(rdata), .s_axi_RLAST(rlast),
        .s_axi_RID(rid), .s_axi_RRESP(rresp), .s_axi_RREADY(rready),
        .req_cnt(req_cnt), .beat_cnt(beat_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [ID_WIDTH-1:0] id;
        logic [63:0]         addr;
        int                  len;
        logic [1:0]          burst;
        int                  acc;
    } mreq_t;

    mreq_t       mq[$];
    mreq_t       nr;
    int          cyc = 0;
    logic        rst_prev = 1'b0;
    bit          m_active = 0;
    int          m_idx = 0;
    int          last_end = -1000;
    int unsigned m_req = 0;
    int unsigned m_beat = 0;
    int          first_rv = -1;
    int          last_rv = -1;
    int          last_acc = -1;
    int          n_slverr = 0;
    int          rr_mode = 0;  // 0 always ready, 1 never, 2 toggle, 3 random

    task automatic check_data(input string name, input logic [63:0] ea);
        logic [63:0] lane_v;
        lane_v = rdata[63:0];
        for (int l = 0; l < LANES; l++) begin
            if (rdata[l*64 +: 64] !== ea) begin
                lane_v = rdata[l*64 +: 64];
                break;
            end
        end
        check(name, lane_v, ea);
    endtask

    // Compare process: inputs change just after posedge, so at negedge the
    // model sees this cycle's inputs and the DUT's state after the last edge.
    always @(negedge clk) begin
        logic [63:0] ea;
        bit          exp_ready;
        if (!rst_prev) begin
            mq.delete();
            m_active = 0;
            last_end = -1000;
            m_req    = 0;
            m_beat   = 0;
            check("rst_arready", 64'(arready), 64'd0);
            check("rst_rvalid",  64'(rvalid),  64'd0);
            check("rst_rlast",   64'(rlast),   64'd0);
            check("rst_rid",     64'(rid),     64'd0);
            check("rst_rresp",   64'(rresp),   64'd0);
            check_data("rst_rdata", 64'd0);
            check("rst_req_cnt",  64'(req_cnt),  64'd0);
            check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        end else begin
            exp_ready = (mq.size() < DEPTH);
            if (!m_active && mq.size() > 0 &&
                cyc >= mq[0].acc + LATENCY && cyc >= last_end + 2) begin
                m_active = 1;
                m_idx    = 0;
            end
            check("arready",  64'(arready),  64'(exp_ready));
            check("rvalid",   64'(rvalid),   64'(m_active));
            check("req_cnt",  64'(req_cnt),  64'(m_req));
            check("beat_cnt", 64'(beat_cnt), 64'(m_beat));
            if (m_active) begin
                ea = (mq[0].burst == BURST_FIXED) ? mq[0].addr
                                                  : ((mq[0].addr + 64'(m_idx * BYTES)) & AMASK);
                check_data("rdata", ea);
                check("rlast", 64'(rlast), 64'(m_idx == mq[0].len));
                check("rid",   64'(rid),   64'(mq[0].id));
                check("rresp", 64'(rresp), (mq[0].burst == 2'b11) ? 64'd2 : 64'd0);
                if (first_rv < 0) first_rv = cyc;
                last_rv = cyc;
                if (rready) begin
                    m_beat++;
                    if (rresp == 2'b10) n_slverr++;
                    if (m_idx == mq[0].len) begin
                        void'(mq.pop_front());
                        m_active = 0;
                        last_end = cyc;
                    end else begin
                        m_idx++;
                    end
                end
            end
            if (arvalid && exp_ready) begin
                nr.id    = arid;
                nr.addr  = 64'(araddr) & ~64'(BYTES - 1);
                nr.len   = int'(arlen);
                nr.burst = arburst;
                nr.acc   = cyc;
                mq.push_back(nr);
                m_req++;
                last_acc = cyc;
            end
        end
        rst_prev = rst_n;
        cyc++;
    end

    // RREADY pattern generator.
    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       rready = 1'b1;
            1:       rready = 1'b0;
            2:       rready = ~rready;
            default: rready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic send_ar(input logic [63:0] addr, input logic [ID_WIDTH-1:0] id,
                           input logic [3:0] len, input logic [1:0] burst);
        bit done = 0;
        arvalid = 1'b1;
        araddr  = addr[ADDR_WIDTH-1:0];
        arid    = id;
        arlen   = len;
        arburst = burst;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            done = arready;
            @(posedge clk);
            #1;
        end
        arvalid = 1'b0;
        if (!done) check("ar_accept_timeout", 64'(done), 64'd1);
    endtask

    task automatic do_reset(input int cycles);
        arvalid = 1'b0;
        rst_n   = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = (mq.size() == 0) && !m_active;
        end
        check("drain_timeout", 64'(ok), 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_rvalid();
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            #1;
            found = rvalid;
        end
        check("rvalid_seen", 64'(found), 64'd1);
    endtask

    task automatic wait_beats(input int unsigned n);
        bit found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            #1;
            found = (beat_cnt == n);
        end
        check("beat_wait", 64'(found), 64'd1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        @(posedge clk);
        #1;
        do_reset(3);

        // Single INCR request: latency and first two beat patterns pinned by hand.
        rr_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        send_ar(64'h1010, 5'd3, 4'd1, BURST_INCR);
        wait_rvalid();
        check("t1_latency", 64'(cyc - 1 - last_acc), 64'd16);
        check("t1_b0_data", rdata[63:0], 64'h1000);
        check("t1_b0_top",  rdata[DATA_WIDTH-1 -: 64], 64'h1000);
        check("t1_b0_rid",  64'(rid), 64'd3);
        check("t1_b0_resp", 64'(rresp), 64'd0);
        check("t1_b0_last", 64'(rlast), 64'd0);
        @(negedge clk);
        #1;
        check("t1_b1_data", rdata[63:0], 64'h1020);
        check("t1_b1_last", 64'(rlast), 64'd1);
        check("t1_b1_rid",  64'(rid), 64'd3);
        drain();

        // Queue fill with RREADY held low.
        do_reset(2);
        rr_mode = 1;
        fork
            begin
                for (int i = 0; i < 10; i++) send_ar(64'(i * 64), 5'(i), 4'd1, BURST_INCR);
            end
            begin
                bit hit = 0;
                for (int i = 0; i < 200 && !hit; i++) begin
                    @(negedge clk);
                    #1;
                    hit = (req_cnt == 32'd8);
                end
                repeat (3) @(negedge clk);
                #1;
                check("fill_arready", 64'(arready), 64'd0);
                check("fill_req_cnt", 64'(req_cnt), 64'd8);
                rr_mode = 0;
            end
        join
        drain();
        check("fill_req_end",  64'(req_cnt),  64'd10);
        check("fill_beat_end", 64'(beat_cnt), 64'd20);

        // 16-beat burst with RREADY toggling every cycle.
        do_reset(2);
        rr_mode = 2;
        send_ar(64'h1_2345_6780, 5'd17, 4'd15, BURST_INCR);
        drain();
        check("toggle_beats", 64'(beat_cnt), 64'd16);

        // FIXED burst and reserved burst encoding.
        do_reset(2);
        rr_mode   = 0;
        n_slverr  = 0;
        send_ar(64'h40, 5'd9, 4'd3, BURST_FIXED);
        send_ar(64'h200, 5'd10, 4'd1, 2'b11);
        drain();
        check("fixed_rsvd_beats", 64'(beat_cnt), 64'd6);
        check("rsvd_slverr_beats", 64'(n_slverr), 64'd2);

        // Reset asserted during beat 3 of a burst with four more queued.
        do_reset(2);
        rr_mode = 0;
        for (int i = 0; i < 5; i++) send_ar(64'(32'h8000 + i * 512), 5'(20 + i), 4'd15, BURST_INCR);
        wait_beats(2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("midrst_beat_cnt", 64'(beat_cnt), 64'd0);
        check("midrst_req_cnt",  64'(req_cnt),  64'd0);
        send_ar(64'h2000, 5'd1, 4'd0, BURST_WRAP);
        drain();
        check("midrst_resume", 64'(beat_cnt), 64'd1);

        // Randomised requests, including addresses near the top of the space.
        do_reset(2);
        rr_mode = 3;
        for (int i = 0; i < 40; i++) begin
            logic [63:0] a;
            a = {$urandom, $urandom} & AMASK;
            if ($urandom_range(0, 4) == 0) a = AMASK - 64'($urandom_range(0, 300));
            send_ar(a, 5'($urandom), 4'($urandom), 2'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();

        // 64 back-to-back 16-beat bursts at full throughput.
        do_reset(2);
        rr_mode  = 0;
        first_rv = -1;
        for (int i = 0; i < 64; i++) send_ar(64'(i * 4096), 5'(i), 4'd15, BURST_INCR);
        drain();
        check("b2b_beats", 64'(beat_cnt), 64'd1024);
        check("b2b_reqs",  64'(req_cnt),  64'd64);
        check("b2b_span",  64'(last_rv - first_rv), 64'd1086);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
